// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// The requester drives start and the operands; the divider returns busy, done and the results.
interface seq_divider_if #(
  parameter int BITS = 64
);
  logic            start;
  logic [BITS-1:0] dividend;
  logic [BITS-1:0] divisor;
  logic            busy;
  logic            done;
  logic [BITS-1:0] quotient;
  logic [BITS-1:0] remainder;
  logic            div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, start/busy/done handshake.
//   state | meaning
//   IDLE  | waiting for start; results and div_zero held
//   RUN   | one shift/subtract step per cycle, count runs BITS-1 down to 0
//   FIN   | done pulse cycle, start ignored
module seq_divider #(
  parameter int BITS = 64
) (
  input logic         clk,
  input logic         reset,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(BITS);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state;
  logic [BITS-1:0] r_q;
  logic [BITS-1:0] q_q;
  logic [BITS-1:0] div_q;
  logic [BITS-1:0] quot_q;
  logic [BITS-1:0] rem_q;
  logic [CW-1:0]   count;
  logic            busy_q;
  logic            done_q;
  logic            dz_q;

  logic [BITS:0]   r_sh;
  logic [BITS:0]   diff;
  logic            borrow;
  logic [BITS-1:0] r_next;
  logic [BITS-1:0] q_next;

  // Partial remainder stays below the divisor, so the shifted value is below
  // 2*divisor; in BITS+1-bit arithmetic the top bit of A + ~B + 1 is the borrow.
  assign r_sh   = {r_q, q_q[BITS-1]};
  assign diff   = r_sh + ~{1'b0, div_q} + {{BITS{1'b0}}, 1'b1};
  assign borrow = diff[BITS];
  assign r_next = borrow ? r_sh[BITS-1:0] : diff[BITS-1:0];
  assign q_next = {q_q[BITS-2:0], ~borrow};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      r_q    <= '0;
      q_q    <= '0;
      div_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              quot_q <= '1;
              rem_q  <= bus.dividend;
              dz_q   <= 1'b1;
              done_q <= 1'b1;
              state  <= FIN;
            end else begin
              div_q  <= bus.divisor;
              r_q    <= '0;
              q_q    <= bus.dividend;
              count  <= CW'(BITS - 1);
              dz_q   <= 1'b0;
              busy_q <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          r_q <= r_next;
          q_q <= q_next;
          if (count == '0) begin
            // Results are registered on entry to FIN so they line up with done.
            quot_q <= q_next;
            rem_q  <= r_next;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= FIN;
          end else begin
            count <= count - 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes arithmetic-model results with their
// expected done cycle, a negedge monitor pops and compares whenever done is seen.
module tb_seq_divider;
  localparam int BITS = 64;

  typedef struct {
    logic [63:0] n;
    logic [63:0] d;
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int          acc;
    int          exp;
  } item_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  item_t       sb[$];
  logic [63:0] last_q = '0;
  logic [63:0] last_r = '0;
  logic        last_dz = 1'b0;

  seq_divider_if #(.BITS(BITS)) bus ();

  seq_divider #(.BITS(BITS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: plain unsigned arithmetic plus the documented latencies.
  function automatic item_t model(input logic [63:0] n, input logic [63:0] d, input int acc);
    item_t it;
    it.n   = n;
    it.d   = d;
    it.acc = acc;
    if (d == 64'd0) begin
      it.q   = '1;
      it.r   = n;
      it.dz  = 1'b1;
      it.exp = acc;
    end else begin
      it.q   = n / d;
      it.r   = n % d;
      it.dz  = 1'b0;
      it.exp = acc + BITS;
    end
    return it;
  endfunction

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Called at a negedge while the DUT is idle; returns the expected done cycle.
  task automatic present(input logic [63:0] n, input logic [63:0] d, output int exp);
    item_t it;
    bus.start    = 1'b1;
    bus.dividend = n;
    bus.divisor  = d;
    it = model(n, d, cyc + 1);
    sb.push_back(it);
    exp = it.exp;
  endtask

  task automatic issue(input logic [63:0] n, input logic [63:0] d, output int exp);
    present(n, d, exp);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = rnd64();
    bus.divisor  = rnd64();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      logic  exp_busy;
      logic  in_run;
      if (sb.size() > 0 && cyc > sb[0].exp) begin
        checks++;
        errors++;
        $display("FAIL missing_done: no done by cycle %0d, expected at %0d", cyc, sb[0].exp);
        void'(sb.pop_front());
      end
      in_run   = sb.size() > 0 && !sb[0].dz && cyc >= sb[0].acc && cyc < sb[0].exp;
      exp_busy = in_run;
      chk("busy", 64'(bus.busy), 64'(exp_busy));
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done at cycle %0d: got done=1, expected 0", cyc);
        end else begin
          item_t it;
          it = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(it.exp));
          chk("quotient", bus.quotient, it.q);
          chk("remainder", bus.remainder, it.r);
          chk("div_zero", 64'(bus.div_zero), 64'(it.dz));
          if (!it.dz) begin
            logic [127:0] recon;
            recon = {64'd0, bus.quotient} * {64'd0, it.d} + {64'd0, bus.remainder};
            chk("invariant_qdr", recon[63:0] ^ 64'(|recon[127:64]), it.n);
            chk("rem_lt_div", 64'(bus.remainder < it.d), 64'd1);
          end
          last_q  = it.q;
          last_r  = it.r;
          last_dz = it.dz;
        end
      end else if (in_run) begin
        chk("div_zero_run", 64'(bus.div_zero), 64'd0);
      end else if (sb.size() == 0 || cyc < sb[0].acc) begin
        chk("hold_q", bus.quotient, last_q);
        chk("hold_r", bus.remainder, last_r);
        chk("hold_dz", 64'(bus.div_zero), 64'(last_dz));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int n_acc;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    reset        = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_q", bus.quotient, 64'd0);
    chk("rst_r", bus.remainder, 64'd0);
    chk("rst_dz", 64'(bus.div_zero), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    issue(64'd100, 64'd7, e);
    wait_cyc(e + 1);
    issue('1, 64'h8000_0000_0000_0000, e);
    wait_cyc(e + 1);
    issue(64'd5, 64'd9, e);
    wait_cyc(e + 1);
    issue(64'h1234, 64'd0, e);
    wait_cyc(e + 1);
    issue(64'd100, 64'd7, e);
    wait_cyc(e + 1);

    // start while busy with different operands must be ignored
    issue(64'd1000, 64'd3, e);
    repeat (5) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 64'd77;
    bus.divisor  = 64'd5;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(e + 1);

    // reset for one cycle mid-run, when the step counter has reached 30
    issue(64'hFFFF_0000_1234_5678, 64'd12345, e);
    n_acc = e - BITS;
    wait_cyc(n_acc + 33);
    reset = 1'b0;
    sb.delete();
    last_q  = '0;
    last_r  = '0;
    last_dz = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_q", bus.quotient, 64'd0);
    chk("midrst_r", bus.remainder, 64'd0);
    issue(64'd81, 64'd9, e);
    wait_cyc(e + 1);

    // back-to-back with start held high; operands scrambled after each acceptance
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] n;
      logic [63:0] d;
      int          sel;
      sel = int'($urandom_range(0, 15));
      n   = rnd64();
      if (sel[0]) n = n >> $urandom_range(0, 63);
      if (sel == 0)      d = 64'd0;
      else if (sel < 5)  d = 64'($urandom_range(1, 1000));
      else if (sel < 9)  d = rnd64() | 64'h8000_0000_0000_0000;
      else if (sel < 12) d = rnd64() >> $urandom_range(0, 63);
      else               d = rnd64();
      present(n, d, e);
      @(negedge clk);
      bus.dividend = rnd64();
      bus.divisor  = rnd64();
      wait_cyc(e + 1);
    end
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pending", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
